mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/sys_defs.sv | 18 +
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared bus command encoding and memory-arbiter FSM states.
package sys_defs;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      IREQ,
      IRSP,
      DREQ,
      DRSP
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one unified memory bus, one transaction
// at a time, with a per-state watchdog that aborts a stuck transaction.
module mem_arbiter
   import sys_defs::*;
#(
   parameter int unsigned WDOG_MAX = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  imem_cmd,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_rdata,
   output logic        imem_valid,
   output logic        if_stall,
   input  logic [1:0]  dmem_cmd,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_done,
   output logic        dmem_stall,
   output logic [1:0]  mem_cmd,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        bus_error
);

   localparam int unsigned CW = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX);

   arb_state_e    state_q, state_d;
   bus_cmd_e      cmd_q, cmd_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [CW-1:0] wdog_q, wdog_d;
   logic [31:0]   irdata_q, irdata_d;
   logic [31:0]   drdata_q, drdata_d;
   logic          ivalid_q, ivalid_d;
   logic          ddone_q, ddone_d;
   logic          berr_q, berr_d;
   logic          store_done;
   logic          wdog_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cmd_q    <= BUS_NONE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wdog_q   <= '0;
         irdata_q <= '0;
         drdata_q <= '0;
         ivalid_q <= 1'b0;
         ddone_q  <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wdog_q   <= wdog_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         ivalid_q <= ivalid_d;
         ddone_q  <= ddone_d;
         berr_q   <= berr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      irdata_d   = irdata_q;
      drdata_d   = drdata_q;
      ivalid_d   = 1'b0;
      ddone_d    = 1'b0;
      berr_d     = berr_q;
      store_done = 1'b0;
      mem_cmd    = BUS_NONE;
      wdog_hit   = (wdog_q == CW'(WDOG_MAX - 1));

      case (state_q)
         // A request whose completion pulse is showing this cycle is still held
         // by its requester; it must not be issued a second time.
         IDLE: begin
            if (dmem_cmd != BUS_NONE && !ddone_q) begin
               state_d = DREQ;
               cmd_d   = (dmem_cmd == BUS_STORE) ? BUS_STORE : BUS_LOAD;
               addr_d  = dmem_addr;
               wdata_d = dmem_wdata;
            end else if (imem_cmd == BUS_LOAD && !ivalid_q) begin
               state_d = IREQ;
               cmd_d   = BUS_LOAD;
               addr_d  = imem_addr;
               wdata_d = '0;
            end
         end
         IREQ: begin
            mem_cmd = cmd_q;
            if (mem_ready) begin
               state_d = IRSP;
            end else if (wdog_hit) begin
               state_d  = IDLE;
               berr_d   = 1'b1;
               ivalid_d = 1'b1;
               irdata_d = '0;
            end
         end
         IRSP: begin
            if (mem_rvalid) begin
               state_d  = IDLE;
               ivalid_d = 1'b1;
               irdata_d = mem_rdata;
            end else if (wdog_hit) begin
               state_d  = IDLE;
               berr_d   = 1'b1;
               ivalid_d = 1'b1;
               irdata_d = '0;
            end
         end
         DREQ: begin
            mem_cmd = cmd_q;
            if (mem_ready) begin
               if (cmd_q == BUS_STORE) begin
                  state_d    = IDLE;
                  store_done = 1'b1;
               end else begin
                  state_d = DRSP;
               end
            end else if (wdog_hit) begin
               state_d = IDLE;
               berr_d  = 1'b1;
               ddone_d = 1'b1;
               if (cmd_q != BUS_STORE) drdata_d = '0;
            end
         end
         DRSP: begin
            if (mem_rvalid) begin
               state_d  = IDLE;
               ddone_d  = 1'b1;
               drdata_d = mem_rdata;
            end else if (wdog_hit) begin
               state_d  = IDLE;
               berr_d   = 1'b1;
               ddone_d  = 1'b1;
               drdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) wdog_d = '0;
      else if (state_q != IDLE) wdog_d = wdog_q + 1'b1;
      else wdog_d = '0;
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign imem_rdata = irdata_q;
   assign imem_valid = ivalid_q;
   assign dmem_rdata = drdata_q;
   assign dmem_done  = ddone_q | store_done;
   assign bus_error  = berr_q;
   assign if_stall   = (imem_cmd == BUS_LOAD) & ~imem_valid;
   assign dmem_stall = (dmem_cmd != BUS_NONE) & ~dmem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized episodes checked
// against a transaction-level latency/data model.
module tb_mem_arbiter;
   import sys_defs::*;

   localparam int unsigned WDOG = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  imem_cmd, dmem_cmd, mem_cmd;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        imem_valid, if_stall, dmem_done, dmem_stall;
   logic        mem_ready, mem_rvalid, bus_error;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        store;
      logic [31:0] wdata;
      int unsigned rdy;
      int unsigned rv;
   } xact_t;

   xact_t       exp_q[$];
   xact_t       cur;
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] bus_mem [logic [31:0]];
   logic        in_cmd, rv_pend;
   int unsigned cmd_age, rv_cnt;
   logic [31:0] rv_addr;

   always #5 clk = ~clk;

   mem_arbiter #(.WDOG_MAX(WDOG)) dut (
      .clk(clk), .rst(rst),
      .imem_cmd(imem_cmd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .if_stall(if_stall),
      .dmem_cmd(dmem_cmd), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_done(dmem_done), .dmem_stall(dmem_stall),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .bus_error(bus_error)
   );

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F1E;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      imem_cmd = BUS_LOAD; dmem_cmd = BUS_STORE;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd0) begin n_fail++; $display("FAIL reset_mem_cmd: got %0d want 0", mem_cmd); end
      n_checks++; if (imem_valid !== 1'b0 || dmem_done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got valid=%0b done=%0b want 0/0", imem_valid, dmem_done); end
      n_checks++; if (imem_rdata !== 32'h0 || dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", imem_rdata, dmem_rdata); end
      n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error: got %0b want 0", bus_error); end
      n_checks++; if (if_stall !== 1'b1 || dmem_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stalls_follow: got %0b/%0b want 1/1", if_stall, dmem_stall); end
      imem_cmd = BUS_NONE; dmem_cmd = BUS_NONE;
      #1;
      n_checks++; if (if_stall !== 1'b0 || dmem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stalls_idle: got %0b/%0b want 0/0", if_stall, dmem_stall); end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd0 || imem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got cmd=%0d valid=%0b want 0/0", mem_cmd, imem_valid); end
   endtask

   task automatic test_single_fetch();
      @(posedge clk); #1; imem_cmd = BUS_LOAD; imem_addr = 32'h100;
      @(negedge clk);
      n_checks++; if (if_stall !== 1'b1 || mem_cmd !== 2'd0) begin n_fail++; $display("FAIL single_c0: got stall=%0b cmd=%0d want 1/0", if_stall, mem_cmd); end
      @(posedge clk); #1; mem_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL single_issue: got cmd=%0d addr=%h want 1/100", mem_cmd, mem_addr); end
      @(posedge clk); #1; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
      @(negedge clk);
      n_checks++; if (imem_valid !== 1'b0 || if_stall !== 1'b1 || mem_cmd !== 2'd0) begin n_fail++; $display("FAIL single_rsp: got valid=%0b stall=%0b cmd=%0d want 0/1/0", imem_valid, if_stall, mem_cmd); end
      @(posedge clk); #1; mem_rvalid = 1'b0; mem_rdata = '0;
      @(negedge clk);
      n_checks++; if (imem_valid !== 1'b1 || imem_rdata !== 32'h0050_0093 || if_stall !== 1'b0) begin n_fail++; $display("FAIL single_valid: got valid=%0b rdata=%h stall=%0b want 1/00500093/0", imem_valid, imem_rdata, if_stall); end
      @(posedge clk); #1; imem_cmd = BUS_NONE;
      @(negedge clk);
      n_checks++; if (imem_valid !== 1'b0 || imem_rdata !== 32'h0050_0093 || mem_cmd !== 2'd0) begin n_fail++; $display("FAIL single_hold: got valid=%0b rdata=%h cmd=%0d want 0/00500093/0", imem_valid, imem_rdata, mem_cmd); end
   endtask

   task automatic test_collision();
      @(posedge clk); #1;
      imem_cmd = BUS_LOAD; imem_addr = 32'h104; dmem_cmd = BUS_LOAD; dmem_addr = 32'h2000;
      @(negedge clk);
      n_checks++; if (if_stall !== 1'b1 || dmem_stall !== 1'b1) begin n_fail++; $display("FAIL coll_c0: got stalls %0b/%0b want 1/1", if_stall, dmem_stall); end
      @(posedge clk); #1; mem_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd1 || mem_addr !== 32'h2000 || if_stall !== 1'b1) begin n_fail++; $display("FAIL coll_first: got cmd=%0d addr=%h stall=%0b want 1/2000/1", mem_cmd, mem_addr, if_stall); end
      @(posedge clk); #1; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      @(negedge clk);
      n_checks++; if (dmem_done !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL coll_drsp: got done=%0b stall=%0b want 0/1", dmem_done, if_stall); end
      @(posedge clk); #1; mem_rvalid = 1'b0;
      @(negedge clk);
      n_checks++; if (dmem_done !== 1'b1 || dmem_rdata !== 32'h1111_2222 || imem_valid !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL coll_ddone: got done=%0b rdata=%h ivalid=%0b stall=%0b want 1/11112222/0/1", dmem_done, dmem_rdata, imem_valid, if_stall); end
      @(posedge clk); #1; dmem_cmd = BUS_NONE; mem_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd1 || mem_addr !== 32'h104 || if_stall !== 1'b1 || dmem_done !== 1'b0) begin n_fail++; $display("FAIL coll_second: got cmd=%0d addr=%h stall=%0b done=%0b want 1/104/1/0", mem_cmd, mem_addr, if_stall, dmem_done); end
      @(posedge clk); #1; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
      @(negedge clk);
      n_checks++; if (if_stall !== 1'b1 || imem_valid !== 1'b0) begin n_fail++; $display("FAIL coll_irsp: got stall=%0b valid=%0b want 1/0", if_stall, imem_valid); end
      @(posedge clk); #1; mem_rvalid = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_valid !== 1'b1 || imem_rdata !== 32'h3333_4444 || if_stall !== 1'b0) begin n_fail++; $display("FAIL coll_ivalid: got valid=%0b rdata=%h stall=%0b want 1/33334444/0", imem_valid, imem_rdata, if_stall); end
      @(posedge clk); #1; imem_cmd = BUS_NONE;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd0 || imem_valid !== 1'b0) begin n_fail++; $display("FAIL coll_end: got cmd=%0d valid=%0b want 0/0", mem_cmd, imem_valid); end
   endtask

   task automatic test_store();
      int n_store_cycles = 0;
      @(posedge clk); #1;
      dmem_cmd = BUS_STORE; dmem_addr = 32'h3000; dmem_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1; mem_ready = (c == 3);
         @(negedge clk);
         if (mem_cmd === 2'd2) n_store_cycles++;
         n_checks++; if (mem_addr !== 32'h3000 || mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_bus_c%0d: got addr=%h wdata=%h want 3000/deadbeef", c, mem_addr, mem_wdata); end
         n_checks++; if (dmem_done !== (c == 3) || dmem_stall !== (c != 3)) begin n_fail++; $display("FAIL store_done_c%0d: got done=%0b stall=%0b want %0b/%0b", c, dmem_done, dmem_stall, (c == 3), (c != 3)); end
      end
      n_checks++; if (n_store_cycles != 3) begin n_fail++; $display("FAIL store_cmd_cycles: got %0d want 3", n_store_cycles); end
      @(posedge clk); #1; mem_ready = 1'b0; dmem_cmd = BUS_NONE;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd0 || dmem_done !== 1'b0 || dmem_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL store_after: got cmd=%0d done=%0b rdata=%h want 0/0/11112222", mem_cmd, dmem_done, dmem_rdata); end
   endtask

   task automatic responder();
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rv_pend) begin
         if (rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = bus_mem.exists(rv_addr) ? bus_mem[rv_addr] : init_word(rv_addr);
            rv_pend    = 1'b0;
         end else begin
            rv_cnt--;
            mem_ready = 1'($urandom_range(0, 1));
         end
      end else if (mem_cmd != 2'd0) begin
         if (!in_cmd) begin
            in_cmd = 1'b1; cmd_age = 0;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_unexpected_cmd: got cmd=%0d addr=%h want no request", mem_cmd, mem_addr);
               cur = '{mem_addr, mem_cmd == 2'd2, mem_wdata, 0, 0};
            end else begin
               cur = exp_q.pop_front();
            end
         end
         if (cmd_age == cur.rdy) begin
            mem_ready = 1'b1; in_cmd = 1'b0;
            n_checks++;
            if (mem_cmd !== (cur.store ? 2'd2 : 2'd1) || mem_addr !== cur.addr || (cur.store && mem_wdata !== cur.wdata)) begin
               n_fail++; $display("FAIL rand_bus_req: got cmd=%0d addr=%h wdata=%h want cmd=%0d addr=%h wdata=%h", mem_cmd, mem_addr, mem_wdata, cur.store ? 2 : 1, cur.addr, cur.wdata);
            end
            if (mem_cmd == 2'd2) bus_mem[mem_addr] = mem_wdata;
            else begin rv_pend = 1'b1; rv_cnt = cur.rv; rv_addr = mem_addr; end
         end else begin
            cmd_age++;
            mem_rvalid = 1'($urandom_range(0, 1));
         end
      end else begin
         mem_ready  = 1'($urandom_range(0, 1));
         mem_rvalid = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic test_random();
      in_cmd = 1'b0; rv_pend = 1'b0; cmd_age = 0; rv_cnt = 0; rv_addr = '0;
      for (int ep = 0; ep < 24; ep++) begin
         int unsigned sel = $urandom_range(0, 2);
         logic has_i = (sel != 1);
         logic has_d = (sel != 0);
         logic d_store = 1'($urandom_range(0, 1));
         logic [31:0] ia = 32'($urandom_range(0, 1023)) << 2;
         logic [31:0] da = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
         logic [31:0] dw = $urandom;
         int unsigned ri = $urandom_range(0, 3), vi = $urandom_range(0, 3);
         int unsigned rd = $urandom_range(0, 3), vd = $urandom_range(0, 3);
         int exp_ti = -1, exp_td = -1, t_i = -1, t_d = -1, accept_i = 0;
         logic [31:0] exp_id = '0, exp_dd = '0, got_id = '0, got_dd = '0;
         logic i_pend, d_pend;

         if (has_d) begin
            exp_td = d_store ? int'(1 + rd) : int'(3 + rd + vd);
            if (d_store) ref_mem[da] = dw;
            else exp_dd = ref_mem.exists(da) ? ref_mem[da] : init_word(da);
            exp_q.push_back('{da, d_store, dw, rd, vd});
         end
         if (has_i) begin
            if (has_d) accept_i = d_store ? int'(2 + rd) : exp_td;
            exp_ti = accept_i + int'(3 + ri + vi);
            exp_id = ref_mem.exists(ia) ? ref_mem[ia] : init_word(ia);
            exp_q.push_back('{ia, 1'b0, 32'h0, ri, vi});
         end

         i_pend = has_i; d_pend = has_d;
         for (int cyc = 0; cyc < 60 && (i_pend || d_pend); cyc++) begin
            @(posedge clk); #1;
            imem_cmd = i_pend ? BUS_LOAD : BUS_NONE; imem_addr = ia;
            dmem_cmd = d_pend ? (d_store ? BUS_STORE : BUS_LOAD) : BUS_NONE;
            dmem_addr = da; dmem_wdata = dw;
            responder();
            @(negedge clk);
            if (d_pend && dmem_done === 1'b1) begin t_d = cyc; got_dd = dmem_rdata; d_pend = 1'b0; end
            if (i_pend && imem_valid === 1'b1) begin t_i = cyc; got_id = imem_rdata; i_pend = 1'b0; end
         end

         n_checks++; if (i_pend || d_pend) begin n_fail++; $display("FAIL rand_timeout ep%0d: got pending i=%0b d=%0b want both complete", ep, i_pend, d_pend); end
         if (has_d) begin
            n_checks++; if (t_d != exp_td) begin n_fail++; $display("FAIL rand_dmem_latency ep%0d: got cycle %0d want %0d", ep, t_d, exp_td); end
            if (!d_store) begin
               n_checks++; if (got_dd !== exp_dd) begin n_fail++; $display("FAIL rand_dmem_data ep%0d: got %h want %h", ep, got_dd, exp_dd); end
            end
         end
         if (has_i) begin
            n_checks++; if (t_i != exp_ti) begin n_fail++; $display("FAIL rand_imem_latency ep%0d: got cycle %0d want %0d", ep, t_i, exp_ti); end
            n_checks++; if (got_id !== exp_id) begin n_fail++; $display("FAIL rand_imem_data ep%0d: got %h want %h", ep, got_id, exp_id); end
         end

         @(posedge clk); #1;
         imem_cmd = BUS_NONE; dmem_cmd = BUS_NONE;
         responder();
         @(negedge clk);
         n_checks++; if (imem_valid !== 1'b0 || dmem_done !== 1'b0 || mem_cmd !== 2'd0) begin n_fail++; $display("FAIL rand_quiet ep%0d: got valid=%0b done=%0b cmd=%0d want 0/0/0", ep, imem_valid, dmem_done, mem_cmd); end
         exp_q.delete();
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_watchdog();
      @(posedge clk); #1; imem_cmd = BUS_LOAD; imem_addr = 32'h200;
      @(negedge clk);
      for (int k = 1; k <= int'(WDOG); k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++; if (mem_cmd !== 2'd1 || bus_error !== 1'b0 || imem_valid !== 1'b0) begin n_fail++; $display("FAIL wdog_wait_c%0d: got cmd=%0d err=%0b valid=%0b want 1/0/0", k, mem_cmd, bus_error, imem_valid); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (bus_error !== 1'b1 || imem_valid !== 1'b1 || imem_rdata !== 32'h0) begin n_fail++; $display("FAIL wdog_fire: got err=%0b valid=%0b rdata=%h want 1/1/0", bus_error, imem_valid, imem_rdata); end
      n_checks++; if (mem_cmd !== 2'd0 || if_stall !== 1'b0) begin n_fail++; $display("FAIL wdog_idle: got cmd=%0d stall=%0b want 0/0", mem_cmd, if_stall); end
      @(posedge clk); #1; imem_cmd = BUS_NONE;
      @(negedge clk);
      n_checks++; if (bus_error !== 1'b1 || imem_valid !== 1'b0 || mem_cmd !== 2'd0) begin n_fail++; $display("FAIL wdog_sticky: got err=%0b valid=%0b cmd=%0d want 1/0/0", bus_error, imem_valid, mem_cmd); end
   endtask

   task automatic test_reset_in_irsp();
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_clears_error: got %0b want 0", bus_error); end
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; imem_cmd = BUS_LOAD; imem_addr = 32'h400;
      @(posedge clk); #1; mem_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_cmd !== 2'd1 || mem_addr !== 32'h400) begin n_fail++; $display("FAIL rst_pre_issue: got cmd=%0d addr=%h want 1/400", mem_cmd, mem_addr); end
      @(posedge clk); #1; mem_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_valid !== 1'b0 || mem_cmd !== 2'd0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got valid=%0b cmd=%0d err=%0b want 0/0/0", imem_valid, mem_cmd, bus_error); end
      n_checks++; if (imem_rdata !== 32'h0 || dmem_rdata !== 32'h0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_data: got %h/%h stall=%0b want 0/0/1", imem_rdata, dmem_rdata, if_stall); end
      @(posedge clk); #1; rst = 1'b0; imem_cmd = BUS_NONE; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      n_checks++; if (imem_valid !== 1'b0 || mem_cmd !== 2'd0) begin n_fail++; $display("FAIL rst_late_rvalid: got valid=%0b cmd=%0d want 0/0", imem_valid, mem_cmd); end
      @(posedge clk); #1; mem_rvalid = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_valid !== 1'b0 || imem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_after: got valid=%0b rdata=%h want 0/0", imem_valid, imem_rdata); end
   endtask

   initial begin
      rst = 1'b1;
      imem_cmd = BUS_NONE; imem_addr = '0;
      dmem_cmd = BUS_NONE; dmem_addr = '0; dmem_wdata = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      test_reset();
      test_single_fetch();
      test_collision();
      test_store();
      test_random();
      test_watchdog();
      test_reset_in_irsp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish want finish before 100000ns");
      $fatal(1, "simulation time limit reached");
   end

endmodule
